// File: rtl/cache_refill_buffer_pkg.sv
// Shared geometry and FSM encoding for the cache line refill path.
package cache_defs;

    localparam int DATA_WIDTH      = 32;
    localparam int Cache_line_size = 512;
    localparam int NUM_BEATS       = Cache_line_size / DATA_WIDTH;
    localparam int OFF_LEN         = $clog2(NUM_BEATS);
    localparam int BYTE_OFF        = $clog2(DATA_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } refill_state_t;

endpackage

// File: rtl/cache_refill_buffer_line_word_insert.sv
// Replaces one word-wide slice of a cache line; inverse of the word-select helper.
module line_word_insert
    import cache_defs::*;
(
    input  logic [OFF_LEN-1:0]         offset,
    input  logic [DATA_WIDTH-1:0]      word,
    input  logic [Cache_line_size-1:0] line_in,
    output logic [Cache_line_size-1:0] line_out
);

    // Each slot takes the new word when selected, otherwise passes the old content.
    always_comb begin
        line_out = line_in;
        for (int k = 0; k < NUM_BEATS; k++) begin
            line_out[k*DATA_WIDTH +: DATA_WIDTH] =
                (offset == OFF_LEN'(k)) ? word : line_in[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/cache_refill_buffer.sv
// Builds one cache line from a burst of read beats, forwards the critical word,
// and hands the finished line to the controller via valid/ready.
module cache_refill_buffer
    import cache_defs::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    input  logic                       rd_valid,
    output logic                       rd_ready,
    input  logic [DATA_WIDTH-1:0]      rd_data,
    input  logic                       rd_last,
    input  logic                       rd_err,
    output logic                       word_valid,
    output logic [DATA_WIDTH-1:0]      word_data,
    output logic                       line_valid,
    input  logic                       line_ready,
    output logic [Cache_line_size-1:0] line_data,
    output logic                       line_err,
    output logic                       busy
);

    localparam logic [OFF_LEN-1:0] LAST_SLOT = OFF_LEN'(NUM_BEATS - 1);
    localparam logic [OFF_LEN-1:0] CNT_ONE   = OFF_LEN'(1);

    refill_state_t              state_r, state_next_s;
    logic [OFF_LEN-1:0]         cnt_r, cnt_next_s;
    logic [OFF_LEN-1:0]         off_r, off_next_s;
    logic [Cache_line_size-1:0] line_r, line_next_s;
    logic                       err_r, err_next_s;
    logic [Cache_line_size-1:0] ins_line_s;
    logic                       last_slot_s;
    logic                       addr_unused_s;

    // Only the word offset of the miss address matters; bursts are line-aligned.
    assign addr_unused_s = ^{req_addr[ADDR_WIDTH-1:BYTE_OFF+OFF_LEN], req_addr[BYTE_OFF-1:0]};
    assign last_slot_s   = (cnt_r == LAST_SLOT);

    line_word_insert u_insert (
        .offset   (cnt_r),
        .word     (rd_data),
        .line_in  (line_r),
        .line_out (ins_line_s)
    );

    // State and datapath registers; reset drops any fill or pending line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            off_r   <= '0;
            line_r  <= '0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            off_r   <= off_next_s;
            line_r  <= line_next_s;
            err_r   <= err_next_s;
        end
    end

    // Next-state logic: accept request, collect beats, hold line until consumed.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        off_next_s   = off_r;
        line_next_s  = line_r;
        err_next_s   = err_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    off_next_s   = req_addr[BYTE_OFF +: OFF_LEN];
                    line_next_s  = '0;
                    err_next_s   = 1'b0;
                    cnt_next_s   = '0;
                    state_next_s = FILL;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FILL: begin
                if (rd_valid) begin
                    line_next_s = ins_line_s;
                    // Early or late last beat is a burst-length mismatch.
                    err_next_s  = err_r | rd_err | (rd_last ^ last_slot_s);
                    if (rd_last || last_slot_s) begin
                        state_next_s = DONE;
                    end else begin
                        cnt_next_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_next_s = FILL;
                end
            end
            DONE: begin
                if (line_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Outputs decode directly from registered state; critical word is a zero-latency bypass.
    assign req_ready  = (state_r == IDLE);
    assign rd_ready   = (state_r == FILL);
    assign word_valid = (state_r == FILL) & rd_valid & (cnt_r == off_r);
    assign word_data  = rd_data;
    assign line_valid = (state_r == DONE);
    assign line_data  = line_r;
    assign line_err   = err_r;
    assign busy       = (state_r != IDLE);

endmodule
